// File: rtl/instr_fetch_queue_if.sv
// Fetch-to-decode handshake bundle for instr_fetch_queue.
// The slave modport is the queue's view; the master modport is the environment's view.
interface instr_fetch_queue_if #(
  parameter int WIDTH    = 32,
  parameter int PC_WIDTH = 32,
  parameter int DEPTH    = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                flush;
  logic                in_valid;
  logic                in_ready;
  logic [WIDTH-1:0]    in_instr;
  logic [PC_WIDTH-1:0] in_pc;
  logic                out_valid;
  logic                out_ready;
  logic [WIDTH-1:0]    out_instr;
  logic [PC_WIDTH-1:0] out_pc;
  logic [CNT_W-1:0]    count;

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_instr, out_pc, count
  );

  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, count
  );
endinterface

// File: rtl/instr_fetch_queue.sv
// DEPTH-entry instruction/PC FIFO between fetch and decode, with flush for redirects.
// Optional zero-latency empty-queue bypass enabled by defining IFQ_BYPASS_EN.
module instr_fetch_queue #(
  parameter int WIDTH    = 32,
  parameter int PC_WIDTH = 32,
  parameter int DEPTH    = 4
) (
  input logic                  clk,
  input logic                  reset,
  instr_fetch_queue_if.slave   bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]    r_count;

  logic                w_empty;
  logic                w_full;
  logic                w_bypass;
  logic                w_push;
  logic                w_pop;
  logic [WIDTH-1:0]    w_entry_instr [DEPTH];
  logic [PC_WIDTH-1:0] w_entry_pc    [DEPTH];
  logic [WIDTH-1:0]    w_head_instr;
  logic [PC_WIDTH-1:0] w_head_pc;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_COUNT);

`ifdef IFQ_BYPASS_EN
  // Empty queue with a ready consumer: hand the instruction straight through.
  assign w_bypass = w_empty & bus.out_ready & bus.in_valid & ~bus.flush;
`else
  assign w_bypass = 1'b0;
`endif

  // A bypassed instruction is consumed without touching storage; flush drops pushes.
  assign w_push = bus.in_valid & ~w_full & ~w_bypass & ~bus.flush;
  assign w_pop  = ~w_empty & bus.out_ready;

  // Per-entry storage, written only on an accepted push into that slot.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic                r_instr;
      logic [WIDTH-1:0]    r_instr_q;
      logic [PC_WIDTH-1:0] r_pc_q;
      logic                w_wr_en;

      assign w_wr_en = w_push & (r_wr_ptr == PTR_W'(gi));
      assign r_instr = 1'b0;

      always_ff @(posedge clk) begin
        if (w_wr_en) begin
          r_instr_q <= bus.in_instr;
          r_pc_q    <= bus.in_pc;
        end
      end

      assign w_entry_instr[gi] = r_instr_q;
      assign w_entry_pc[gi]    = r_pc_q;
    end
  endgenerate

  assign w_head_instr = w_entry_instr[r_rd_ptr];
  assign w_head_pc    = w_entry_pc[r_rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (bus.flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    bus.out_instr = '0;
    bus.out_pc    = '0;
    if (w_bypass) begin
      bus.out_instr = bus.in_instr;
      bus.out_pc    = bus.in_pc;
    end else if (!w_empty) begin
      bus.out_instr = w_head_instr;
      bus.out_pc    = w_head_pc;
    end
  end

  // in_ready ignores a same-cycle pop, so a full queue never takes a push.
  assign bus.in_ready  = ~w_full;
  assign bus.out_valid = ~w_empty | w_bypass;
  assign bus.count     = r_count;

endmodule
